// File: rtl/coder_pkg.sv
// Shared types and constants for the coder lane packer.
package coder_pkg;

    localparam int unsigned LANES_DEF  = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned LANE_W     = $clog2(LANES_DEF);
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES);
    localparam int unsigned IDX_W      = 8;

    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef struct packed {
        lane_idx_t                 idx;
        logic [WORD_W-1:0]         word;
        logic [WORD_BYTES-1:0]     keep;
        logic                      last;
    } out_beat_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } packer_state_t;

    // Contiguous byte mask for a partially filled word holding cnt bytes.
    function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [CNT_W-1:0] cnt);
        return WORD_BYTES'((5'd1 << cnt) - 5'd1);
    endfunction

endpackage

// File: rtl/lane_pack_slot.sv
// One lane's partial word buffer and byte count.
module lane_pack_slot
    import coder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_byte,
    input  logic              take,
    output logic [WORD_W-1:0] lane_word,
    output logic [CNT_W-1:0]  cnt
);

    // Append a byte at position cnt; a fourth byte or a take empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_word <= '0;
            cnt       <= '0;
        end else if (take) begin
            lane_word <= '0;
            cnt       <= '0;
        end else if (wr_en) begin
            if (cnt == CNT_W'(WORD_BYTES - 1)) begin
                lane_word <= '0;
                cnt       <= '0;
            end else begin
                lane_word[BYTE_W*cnt +: BYTE_W] <= wr_byte;
                cnt                              <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coder_lane_packer.sv
// Packs per-lane coder bytes into lane-tagged 32-bit LE words, flushing
// partial lanes at end of stream. Optional macro PACKER_PERF_CNT_EN adds
// perf_bytes / perf_words handshake counters.
module coder_lane_packer
    import coder_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_bits_idx,
    input  logic [BYTE_W-1:0]     in_bits_byte,
    input  logic                  in_bits_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_bits_idx,
    output logic [WORD_W-1:0]     out_bits_word,
    output logic [WORD_BYTES-1:0] out_bits_keep,
    output logic                  out_bits_last
`ifdef PACKER_PERF_CNT_EN
    ,
    output logic [31:0]           perf_bytes,
    output logic [31:0]           perf_words
`endif
);

    packer_state_t     state, state_nx;
    lane_idx_t         ptr, ptr_nx;
    out_beat_t         out_q, out_nx;
    logic              out_valid_nx;
    logic              run_en;

    logic [WORD_W-1:0] lane_word [LANES];
    logic [CNT_W-1:0]  lane_cnt  [LANES];
    logic [LANES-1:0]  wr_vec, take_vec;
    logic [LANES-1:0]  busy, busy_after, scan;

    lane_idx_t         in_lane;
    lane_idx_t         pick;
    logic              pick_found, pick_above;
    logic              free_c, accept_c, in_full_c;
    logic              unused_idx_hi;

    assign in_lane       = in_bits_idx[LANE_W-1:0];
    assign unused_idx_hi = ^in_bits_idx[IDX_W-1:LANE_W];
    assign free_c        = !out_valid || out_ready;
    assign in_ready      = run_en && (state == RUN) && free_c;
    assign accept_c      = in_valid && in_ready;
    assign in_full_c     = (lane_cnt[in_lane] == CNT_W'(WORD_BYTES - 1));

    // Lane slots.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_pack_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_vec[g]),
            .wr_byte   (in_bits_byte),
            .take      (take_vec[g]),
            .lane_word (lane_word[g]),
            .cnt       (lane_cnt[g])
        );
    end

    // Occupancy now and as it will be after the current accept.
    always_comb begin
        busy = '0;
        for (int l = 0; l < LANES; l++) begin
            busy[l] = (lane_cnt[l] != '0);
        end
        busy_after = busy;
        if (accept_c) begin
            busy_after[in_lane] = !in_full_c;
        end
    end

    // Priority pick of the lowest occupied lane at or above the scan pointer.
    always_comb begin
        scan       = '0;
        pick       = '0;
        pick_above = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            scan[l] = busy[l] && (l >= int'(ptr));
        end
        for (int l = LANES - 1; l >= 0; l--) begin
            if (scan[l]) begin
                pick = lane_idx_t'(l);
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (scan[l] && (lane_idx_t'(l) > pick)) begin
                pick_above = 1'b1;
            end
        end
        pick_found = |scan;
    end

    // Next-state, lane controls and output register load.
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        out_nx       = out_q;
        out_valid_nx = out_valid && !out_ready;
        wr_vec       = '0;
        take_vec     = '0;
        case (state)
            RUN: begin
                if (accept_c) begin
                    wr_vec[in_lane] = 1'b1;
                    if (in_full_c) begin
                        out_valid_nx = 1'b1;
                        out_nx.idx   = in_lane;
                        out_nx.word  = {in_bits_byte, lane_word[in_lane][WORD_W-BYTE_W-1:0]};
                        out_nx.keep  = '1;
                        out_nx.last  = in_bits_last && !(|busy_after);
                    end
                    if (in_bits_last && (|busy_after)) begin
                        state_nx = FLUSH;
                        ptr_nx   = '0;
                    end
                end
            end
            FLUSH: begin
                if (free_c) begin
                    if (pick_found) begin
                        out_valid_nx   = 1'b1;
                        out_nx.idx     = pick;
                        out_nx.word    = lane_word[pick];
                        out_nx.keep    = keep_mask(lane_cnt[pick]);
                        out_nx.last    = !pick_above;
                        take_vec[pick] = 1'b1;
                        ptr_nx         = pick + 1'b1;
                        if (!pick_above) begin
                            state_nx = RUN;
                        end
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // State and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ptr       <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            run_en    <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            out_q     <= out_nx;
            out_valid <= out_valid_nx;
            run_en    <= 1'b1;
        end
    end

    assign out_bits_idx  = IDX_W'(out_q.idx);
    assign out_bits_word = out_q.word;
    assign out_bits_keep = out_q.keep;
    assign out_bits_last = out_q.last;

`ifdef PACKER_PERF_CNT_EN
    // Free-running handshake counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bytes <= '0;
            perf_words <= '0;
        end else begin
            if (accept_c) begin
                perf_bytes <= perf_bytes + 32'd1;
            end
            if (out_valid && out_ready) begin
                perf_words <= perf_words + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/coder_lane_packer.md
Name: coder_lane_packer

Overview:
Downstream consumer of the Compressor coder output stream, which carries byte, lane idx and last. Packs the per-lane byte stream (8 arithmetic-coder lanes) into 32-bit little-endian words tagged with their lane, so a wide DMA/AXI writer can store each lane's output contiguously. On the end-of-stream beat it flushes all partially filled lanes as keep-masked words. The final word of the stream carries last exactly once.

Parameters:
LANES, 8, number of coder lanes; lane = in_bits_idx[$clog2(LANES)-1:0].
WORD_BYTES, 4, bytes per output word. Fixed at 4 in this revision.

Ports:
clk  in  1  single clock, driven from coder_clk.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  coder byte valid.
in_ready  out  1  packer can accept a byte.
in_bits_idx  in  8  lane index of the byte.
in_bits_byte  in  8  compressed byte.
in_bits_last  in  1  final byte of the whole stream.
out_valid  out  1  word valid.
out_ready  in  1  sink accepts word.
out_bits_idx  out  8  lane of word, zero-extended.
out_bits_word  out  32  packed bytes; first-received byte in [7:0]; unused bytes are 0.
out_bits_keep  out  4  valid-byte mask, always contiguous from bit 0.
out_bits_last  out  1  final word of the stream.

Behaviour:
- Reset (async assert, sync release): state=RUN; out_valid=0; out_bits_*=0; all lane buf=0 and cnt=0; in_ready=0 while rst_n=0.
- Per-lane state: buf[l] 32b and cnt[l] 0..3 (bytes held).
- Single-entry output register. The register is free when !out_valid || out_ready. out_bits_* hold stable while out_valid && !out_ready.
- RUN: in_ready = free.
- RUN, accept of a byte to lane l: byte is written at position cnt[l].
  - cnt[l]<3: cnt[l]++. No output.
  - cnt[l]==3: the full word {byte,buf[l][23:0]} loads the output register next cycle with keep=4'hF; cnt[l]=0; buf[l]=0.
  - Throughput: 1 byte/cycle with out_ready=1. Latency: accept of 4th byte to out_valid = 1 cycle.
- Accept with in_bits_last=1:
  - The byte is packed as above.
  - Let P = the set of lanes with cnt>0 after the update.
  - If a full word was produced, it carries out_bits_last = (P empty).
  - If P is non-empty, go to FLUSH with scan pointer=0. Otherwise stay in RUN.
- FLUSH:
  - in_ready=0.
  - Each cycle with the output register free, the scan pointer moves to the lowest lane ≥ pointer with cnt>0. Empty lanes are skipped within the same cycle via a priority encoder.
  - That lane's word loads the output register: keep=(1<<cnt)-1, word=buf, last=(no nonempty lane above it). The lane is then cleared.
  - After the last-flagged word loads, return to RUN. A new stream may start on the following cycle.
- Flush order is ascending lane index. Only lanes with data emit; a lane never emits a keep=0 word.
- Total words in a stream = Σ ceil(bytes_l/4) over all lanes.
- Lane index ≥ LANES cannot occur with LANES=8 (only idx[2:0] is used; upper bits are ignored).
- Simultaneous events in one cycle: an out_ready drain plus a new load is allowed (back-to-back words).
- Reset mid-stream: all buffered bytes are discarded and no partial flush is performed. An output word pending at reset is dropped.

Optional Feature:
PACKER_PERF_CNT_EN
- Defined: adds outputs perf_bytes[31:0] (count of accepted input beats) and perf_words[31:0] (count of output handshakes). Both are async-reset to 0, increment per handshake and wrap at 2^32. They are cleared by reset only, not per stream.
- Undefined: the ports and counters are absent. Function is otherwise identical.

Decomposition:
- Shared package coder_pkg:
  - LANES_DEF=8, WORD_BYTES=4.
  - typedef lane_idx_t (3b).
  - typedef packed struct out_beat_t {idx, word, keep, last}.
  - enum packer_state_t {RUN, FLUSH}.
- One sub-module, lane_pack_slot: one lane's buf/cnt with write, take and clear controls. Instantiated LANES times via generate.

Test Plan:
- Lane 0 receives bytes 01,02,03,04 (last=0), out_ready=1 -> one word idx=0, word=0x04030201, keep=F, last=0, out_valid 1 cycle after the 4th accept.
- Bytes interleaved lane3,lane5 ×4 each, last on the final byte -> lane3 word first, then lane5 word with last=1. No flush words. Next cycle state=RUN.
- Lane2 gets 3 bytes AA,BB,CC; lane6 gets 1 byte DD with last=1 -> FLUSH emits idx=2 word=0x00CCBBAA keep=7 last=0, then idx=6 word=0x000000DD keep=1 last=1. in_ready=0 throughout the flush.
- Output backpressure: out_ready=0 for 10 cycles while a full word is pending -> in_ready=0, out_bits stable. On release, the next word follows back-to-back.
- Reset asserted mid-FLUSH after the first word -> out_valid=0 immediately. After release, a fresh single byte with last=1 emits exactly one word with keep=1, last=1.
- With PACKER_PERF_CNT_EN: stream of 9 bytes to lane1 with last on the 9th -> perf_bytes=9, perf_words=3, and the final word has keep=1.
